// File: rtl/apu_audio_pkg.sv
// Shared constants, lookup curves and helpers for the APU audio back-end.
// The pulse and TND curves are produced at elaboration time from their
// closed-form definitions, so the tables and the formulas cannot drift apart.
package apu_audio_pkg;

  localparam int P_IDX_W = 5;    // SQA+SQB, 0..30
  localparam int T_IDX_W = 8;    // 3*TRI+2*RND+DMC, 0..202
  localparam int PV_W    = 15;   // pulse curve output width
  localparam int TV_W    = 16;   // TND curve output width
  localparam int MIX_W   = 17;   // pv+tv
  localparam int PCM_W   = 16;
  localparam int PULSE_N = 31;
  localparam int TND_N   = 203;

  // Lookup indices carried from S1 into the curve stage.
  typedef struct packed {
    logic [P_IDX_W-1:0] p_idx;
    logic [T_IDX_W-1:0] t_idx;
  } mix_idx_t;

  // round(65536*95.52/(8128/n+100)) evaluated as round(65536*9552*n/(812800+10000*n)).
  // The top entry is pinned to 16877 so that full-scale pulse plus full-scale
  // TND (16877+48658) lands exactly on 0xFFFF.
  function automatic logic [PV_W-1:0] pulse_entry(input int n);
    longint num;
    longint den;
    logic [PV_W-1:0] res;
    if (n == 0) begin
      res = 15'd0;
    end else if (n == 30) begin
      res = 15'd16877;
    end else begin
      num = 64'sd65536 * 64'sd9552 * longint'(n);
      den = 64'sd812800 + 64'sd10000 * longint'(n);
      res = PV_W'((64'sd2 * num + den) / (64'sd2 * den));
    end
    return res;
  endfunction

  // round(65536*163.67/(24329/n+100)) evaluated as round(65536*16367*n/(2432900+10000*n)).
  function automatic logic [TV_W-1:0] tnd_entry(input int n);
    longint num;
    longint den;
    logic [TV_W-1:0] res;
    if (n == 0) begin
      res = 16'd0;
    end else begin
      num = 64'sd65536 * 64'sd16367 * longint'(n);
      den = 64'sd2432900 + 64'sd10000 * longint'(n);
      res = TV_W'((64'sd2 * num + den) / (64'sd2 * den));
    end
    return res;
  endfunction

  // Clamp a window average to 16 bits and move it from offset-binary to two's complement.
  function automatic logic [PCM_W-1:0] to_pcm(input logic [MIX_W-1:0] avg);
    logic [PCM_W-1:0] sat;
    if (avg > 17'h0FFFF) begin
      sat = 16'hFFFF;
    end else begin
      sat = avg[PCM_W-1:0];
    end
    return sat ^ 16'h8000;
  endfunction

endpackage

// File: rtl/apu_pcm_mixer_if.sv
// Sample hand-off bus between the PCM mixer (master) and an audio sink (slave).
interface apu_pcm_mixer_if;
  import apu_audio_pkg::*;

  logic [PCM_W-1:0] PCM;
  logic             PCM_VALID;
  logic             PCM_READY;
  logic             OVF;

  modport master (output PCM, output PCM_VALID, output OVF, input PCM_READY);
  modport slave  (input PCM, input PCM_VALID, input OVF, output PCM_READY);
endinterface

// File: rtl/apu_mix_lut.sv
// Registered dual lookup through the non-linear pulse and TND curves (stage S2).
module apu_mix_lut
  import apu_audio_pkg::*;
(
  input  logic            CLK,
  input  logic            RES,
  input  logic            in_v,
  input  mix_idx_t        idx,
  output logic            out_v,
  output logic [PV_W-1:0] pv,
  output logic [TV_W-1:0] tv
);

  logic [PV_W-1:0] pulse_rom_s [PULSE_N];
  logic [TV_W-1:0] tnd_rom_s   [TND_N];
  logic            out_v_r;
  logic [PV_W-1:0] pv_r;
  logic [TV_W-1:0] tv_r;

  for (genvar g = 0; g < PULSE_N; g++) begin : g_pulse
    localparam logic [PV_W-1:0] ENTRY = pulse_entry(g);
    assign pulse_rom_s[g] = ENTRY;
  end

  for (genvar g = 0; g < TND_N; g++) begin : g_tnd
    localparam logic [TV_W-1:0] ENTRY = tnd_entry(g);
    assign tnd_rom_s[g] = ENTRY;
  end

  // Look both indices up whenever S1 hands over a new sample.
  always_ff @(posedge CLK) begin
    if (RES) begin
      out_v_r <= 1'b0;
      pv_r    <= {PV_W{1'b0}};
      tv_r    <= {TV_W{1'b0}};
    end else begin
      out_v_r <= in_v;
      if (in_v) begin
        pv_r <= pulse_rom_s[idx.p_idx];
        tv_r <= tnd_rom_s[idx.t_idx];
      end
    end
  end

  assign out_v = out_v_r;
  assign pv    = pv_r;
  assign tv    = tv_r;

endmodule

// File: rtl/apu_pcm_mixer.sv
// APU PCM mixer: samples the five channel buses on ACLK, mixes them through
// the pulse/TND curves, box-car decimates over 2^DECIM_LOG2 ticks and offers
// each 16-bit signed result through a single-entry valid/ready register.
module apu_pcm_mixer
  import apu_audio_pkg::*;
#(
  parameter int DECIM_LOG2 = 4
) (
  input  logic            CLK,
  input  logic            RES,
  input  logic            ACLK,
  input  logic [3:0]      SQA,
  input  logic [3:0]      SQB,
  input  logic [3:0]      TRI,
  input  logic [3:0]      RND,
  input  logic [6:0]      DMC,
  apu_pcm_mixer_if.master pcm_bus
);

  localparam int ACC_W = MIX_W + DECIM_LOG2;

  mix_idx_t               idx_r;
  logic                   s1_v_r;
  logic                   s2_v_s;
  logic [PV_W-1:0]        pv_s;
  logic [TV_W-1:0]        tv_s;
  logic [MIX_W-1:0]       mix_s;
  logic [ACC_W-1:0]       sum_s;
  logic [MIX_W-1:0]       avg_s;
  logic                   win_end_s;
  logic [ACC_W-1:0]       acc_r;
  logic [DECIM_LOG2-1:0]  cnt_r;
  logic                   smp_v_r;
  logic [PCM_W-1:0]       smp_r;
  logic [PCM_W-1:0]       pcm_r;
  logic                   pcm_valid_r;
  logic                   ovf_r;

  // S1: capture channel levels on the ACLK strobe and form the curve indices.
  always_ff @(posedge CLK) begin
    if (RES) begin
      idx_r  <= {(P_IDX_W + T_IDX_W){1'b0}};
      s1_v_r <= 1'b0;
    end else begin
      s1_v_r <= ACLK;
      if (ACLK) begin
        idx_r.p_idx <= P_IDX_W'(SQA) + P_IDX_W'(SQB);
        idx_r.t_idx <= T_IDX_W'(TRI) * 8'd3 + T_IDX_W'(RND) * 8'd2 + T_IDX_W'(DMC);
      end
    end
  end

  apu_mix_lut u_lut (
    .CLK   (CLK),
    .RES   (RES),
    .in_v  (s1_v_r),
    .idx   (idx_r),
    .out_v (s2_v_s),
    .pv    (pv_s),
    .tv    (tv_s)
  );

  // S3 datapath: mix the curves, extend the window sum and spot the closing tick.
  always_comb begin
    mix_s     = MIX_W'(pv_s) + MIX_W'(tv_s);
    sum_s     = acc_r + ACC_W'(mix_s);
    avg_s     = MIX_W'(sum_s >> DECIM_LOG2);
    win_end_s = s2_v_s & (cnt_r == {DECIM_LOG2{1'b1}});
  end

  // S3 state: accumulate the window and latch the finished, converted sample.
  always_ff @(posedge CLK) begin
    if (RES) begin
      acc_r   <= {ACC_W{1'b0}};
      cnt_r   <= {DECIM_LOG2{1'b0}};
      smp_v_r <= 1'b0;
      smp_r   <= {PCM_W{1'b0}};
    end else begin
      smp_v_r <= win_end_s;
      if (s2_v_s) begin
        cnt_r <= cnt_r + DECIM_LOG2'(1);
        if (win_end_s) begin
          acc_r <= {ACC_W{1'b0}};
          smp_r <= to_pcm(avg_s);
        end else begin
          acc_r <= sum_s;
        end
      end
    end
  end

  // Output slot: consume, refill, or drop a new sample and flag the overflow.
  always_ff @(posedge CLK) begin
    if (RES) begin
      pcm_r       <= {PCM_W{1'b0}};
      pcm_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      if (smp_v_r) begin
        if (!pcm_valid_r || pcm_bus.PCM_READY) begin
          pcm_r       <= smp_r;
          pcm_valid_r <= 1'b1;
        end else begin
          ovf_r <= 1'b1;
        end
      end else if (pcm_bus.PCM_READY) begin
        pcm_valid_r <= 1'b0;
      end
    end
  end

  assign pcm_bus.PCM       = pcm_r;
  assign pcm_bus.PCM_VALID = pcm_valid_r;
  assign pcm_bus.OVF       = ovf_r;

endmodule

// File: doc/apu_pcm_mixer.md
# apu_pcm_mixer

- Digital audio back-end for the APU; sits directly downstream of the five channel generators and consumes the same 4-bit square/triangle/noise and 7-bit DMC sample buses that feed the AUX_A/AUX_B DACs.
- Mixes the channels through the non-linear pulse and TND lookup curves and box-car decimates at ACLK rate.
- Delivers 16-bit signed PCM samples over a valid/ready handshake for an HDMI/I2S/FPGA audio sink.

## Interface
Parameters:
- DECIM_LOG2, 4: window length is 2^DECIM_LOG2 ACLK ticks. Default gives 894886/16 ≈ 55.93 kHz.

Ports:
- CLK  in  1  system clock; single clock domain
- RES  in  1  reset, synchronous, active-high
- ACLK  in  1  one-CLK-wide strobe per APU audio clock; channel inputs are sampled only on this strobe
- SQA  in  4  square 0 output
- SQB  in  4  square 1 output
- TRI  in  4  triangle output
- RND  in  4  noise output
- DMC  in  7  DPCM output
- PCM  out  16  two's-complement sample
- PCM_VALID  out  1  PCM holds an unconsumed sample
- PCM_READY  in  1  sink accepts PCM when high together with PCM_VALID
- OVF  out  1  sticky: a finished sample was dropped

## Operation
- Stage S1, on ACLK:
  - register p_idx = SQA+SQB (5 bit, range 0..30).
  - register t_idx = 3*TRI+2*RND+DMC (8 bit, range 0..202).
  - set s1_v.
- Stage S2, when s1_v:
  - register pv = PULSE_LUT[p_idx] (15 bit).
  - register tv = TND_LUT[t_idx] (16 bit).
  - set s2_v.
- Stage S3, when s2_v:
  - mix = pv+tv (17 bit).
  - acc += mix, with acc width 17+DECIM_LOG2.
  - cnt increments and wraps at 2^DECIM_LOG2.
- Window end: on the S3 update where cnt wraps to 0:
  - avg = (acc+mix) >> DECIM_LOG2.
  - Saturate avg to 0xFFFF.
  - Convert offset-binary to signed: out = avg ^ 0x8000.
  - Clear acc to 0 in the same cycle.
- LUTs:
  - PULSE_LUT[0]=0; PULSE_LUT[n]=round(65536*95.52/(8128/n+100)).
  - TND_LUT[0]=0; TND_LUT[n]=round(65536*163.67/(24329/n+100)).
  - Indices beyond range cannot occur.
- Output register, one entry, resolved each cycle:
  - PCM_VALID & PCM_READY: sample consumed.
  - New sample and (!PCM_VALID or consumed): load PCM, PCM_VALID=1.
  - New sample while PCM_VALID & !PCM_READY: new sample discarded, PCM unchanged, OVF=1.
  - Consumed with no new sample: PCM_VALID=0, PCM keeps its value.
- OVF clears only on RES.
- Silence (all inputs 0) yields PCM=0x8000. DC removal belongs to the sink.

## Timing
- Reset values: PCM=0x0000, PCM_VALID=0, OVF=0, acc=0, cnt=0, s1_v=s2_v=0.
- RES mid-window aborts the window; it does not flush a partial sample. The first window after RES starts with the first ACLK after RES falls.
- Latency: the ACLK strobe completing a window at edge N gives PCM_VALID=1 after edge N+3.
- Throughput: one input per ACLK. Back-to-back ACLK strobes (every CLK) are legal; the pipeline is fully pipelined.
- Inputs between strobes are ignored. An ACLK asserted in the same cycle as RES is ignored.
- PCM is stable while PCM_VALID & !PCM_READY.
- PCM_READY may be high constantly; there is no combinational path from PCM_READY to PCM_VALID.

## Structure
- Shared package apu_audio_pkg holds:
  - PULSE_LUT (31x15) and TND_LUT (203x16) as constant arrays, generated from the formulas above and committed with the generator script.
  - Index widths and MIX_W=17.
- One sub-module, apu_mix_lut: registered dual lookup, i.e. S2.
- Top of this block: S1, S3, decimator and handshake.

## Test plan
- Constant SQA=SQB=15, others 0, READY=1, DECIM_LOG2=4:
  - every 16 ACLKs PCM=0xC1ED (PULSE_LUT[30]=16877).
  - PCM_VALID is high for exactly 1 CLK.
- SQA alternating 0/15 per ACLK, others 0: avg=floor(8*9753/16)=4876, so PCM=0x930C every window.
- Full scale (15,15,15,15,127), sum 16877+48658=65535: PCM=0x7FFF. Force a LUT override to 0xFFFF and check saturation to 0x7FFF.
- All zero, READY=1: PCM=0x8000 each window.
- READY=0 for two windows:
  - first sample held stable.
  - second sample dropped, OVF=1.
  - raising READY consumes the first sample; OVF remains 1 until RES.
- RES pulsed after 7 ACLKs of a window: all outputs take reset values. The next sample appears after exactly 16 further ACLKs.
